mdu_iterative: RTL

//  Multi-cycle multiply/divide unit beside the single-cycle ALU in the execute stage.

---
 rtl/mdu_iterative.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, results held in architectural HI/LO.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  opnd_q;
  logic [W2-1:0]     acc_q;
  logic              neg_lo_q;
  logic              neg_hi_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;
  logic              busy_q;
  logic              done_q;

  logic              sgn_op;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic              last;

  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_nxt;
  logic [W2-1:0]     mul_res;
  logic [WIDTH:0]    div_sh;
  logic [WIDTH:0]    div_diff;
  logic              div_ok;
  logic [W2-1:0]     div_nxt;
  logic [WIDTH-1:0]  quo_res;
  logic [WIDTH-1:0]  rem_res;

  assign sgn_op = (MDOp == OP_MULT) || (MDOp == OP_DIV);
  assign mag_a  = (sgn_op && A[WIDTH-1]) ? -A : A;
  assign mag_b  = (sgn_op && B[WIDTH-1]) ? -B : B;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // acc_q holds {partial product, remaining multiplier bits} for MUL
  // and {partial remainder, dividend/quotient bits} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]}
             + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
    mul_res  = neg_lo_q ? -mul_nxt : mul_nxt;
    div_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_ok   = ~div_diff[WIDTH];
    div_nxt  = {div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0],
                acc_q[WIDTH-2:0], div_ok};
    quo_res  = neg_lo_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
    rem_res  = neg_hi_q ? -div_nxt[W2-1:WIDTH] : div_nxt[W2-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            case (MDOp)
              OP_MULT, OP_MULTU: begin
                state_q  <= S_MUL;
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                opnd_q   <= mag_a;
                acc_q    <= {{WIDTH{1'b0}}, mag_b};
                neg_lo_q <= sgn_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_hi_q <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero is swallowed: no state change at all.
                if (B != '0) begin
                  state_q  <= S_DIV;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  opnd_q   <= mag_b;
                  acc_q    <= {{WIDTH{1'b0}}, mag_a};
                  neg_lo_q <= sgn_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                  neg_hi_q <= sgn_op & A[WIDTH-1];
                end
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_q <= mul_nxt;
          if (last) begin
            hi_q    <= mul_res[W2-1:WIDTH];
            lo_q    <= mul_res[WIDTH-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DIV: begin
          acc_q <= div_nxt;
          if (last) begin
            hi_q    <= rem_res;
            lo_q    <= quo_res;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
